bs_port_fifo: RTL and testbench

- Per-device interface stage between one bus agent and the bus generator/arbiter (bs_gnrtr_n_rbtr).
- TX path: a show-ahead FIFO buffers device packets and presents them to the arbiter on pndng/D_pop. The arbiter consumes them with pop.
- RX path: accepts arbiter push/D_push and filters by destination ID or broadcast. Accepted packets are buffered in a second FIFO for the device.
- One instance per driver; the instance index is passed as parameter id.

---
 rtl/bs_port_fifo.sv | 109 ++++++++++
 tb/tb_bs_port_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bs_port_fifo.sv
// Bus port stage: show-ahead TX FIFO towards the arbiter and ID-filtered
// show-ahead RX FIFO towards the device, with sticky overflow and misroute stats.
module bs_port_fifo #(
    parameter int unsigned pckg_sz   = 16,
    parameter int unsigned fifo_size = 16,
    parameter logic [7:0]  id        = 8'd0,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             dev_push,
    input  logic [pckg_sz-1:0]               dev_d_in,
    output logic                             dev_full,
    output logic                             pndng,
    output logic [pckg_sz-1:0]               D_pop,
    input  logic                             pop,
    input  logic                             push,
    input  logic [pckg_sz-1:0]               D_push,
    output logic                             dev_pndng,
    output logic [pckg_sz-1:0]               dev_d_out,
    input  logic                             dev_pop,
    output logic [$clog2(fifo_size+1)-1:0]   tx_cnt,
    output logic [$clog2(fifo_size+1)-1:0]   rx_cnt,
    output logic                             tx_ovf,
    output logic                             rx_ovf,
    output logic [7:0]                       misroute_cnt
);

    localparam int unsigned CntW = $clog2(fifo_size + 1);
    localparam int unsigned PtrW = $clog2(fifo_size);
    localparam logic [CntW-1:0] CntFull = CntW'(fifo_size);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(fifo_size - 1);

    logic [pckg_sz-1:0] r_tx_mem [fifo_size];
    logic [pckg_sz-1:0] r_rx_mem [fifo_size];
    logic [PtrW-1:0]    r_tx_wr_ptr, r_tx_rd_ptr, r_rx_wr_ptr, r_rx_rd_ptr;
    logic [CntW-1:0]    r_tx_cnt, r_rx_cnt;
    logic               r_tx_ovf, r_rx_ovf;
    logic [7:0]         r_misroute_cnt;

    logic       w_tx_full, w_tx_rd, w_tx_wr, w_tx_drop;
    logic       w_rx_full, w_rx_rd, w_rx_wr, w_rx_drop;
    logic [7:0] w_dest;
    logic       w_rx_hit, w_rx_miss;

    // A read frees a slot in the same cycle, so a write to a full FIFO with a read succeeds.
    always_comb begin
        w_tx_full = (r_tx_cnt == CntFull);
        w_tx_rd   = pop && (r_tx_cnt != '0);
        w_tx_wr   = dev_push && (!w_tx_full || w_tx_rd);
        w_tx_drop = dev_push && w_tx_full && !w_tx_rd;

        w_dest    = D_push[pckg_sz-1 -: 8];
        w_rx_hit  = push && ((w_dest == id) || (w_dest == broadcast));
        w_rx_miss = push && !w_rx_hit;

        w_rx_full = (r_rx_cnt == CntFull);
        w_rx_rd   = dev_pop && (r_rx_cnt != '0);
        w_rx_wr   = w_rx_hit && (!w_rx_full || w_rx_rd);
        w_rx_drop = w_rx_hit && w_rx_full && !w_rx_rd;
    end

    // Storage deliberately has no reset.
    always_ff @(posedge clk) begin
        if (w_tx_wr) r_tx_mem[r_tx_wr_ptr] <= dev_d_in;
        if (w_rx_wr) r_rx_mem[r_rx_wr_ptr] <= D_push;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_wr_ptr    <= '0;
            r_tx_rd_ptr    <= '0;
            r_tx_cnt       <= '0;
            r_tx_ovf       <= 1'b0;
            r_rx_wr_ptr    <= '0;
            r_rx_rd_ptr    <= '0;
            r_rx_cnt       <= '0;
            r_rx_ovf       <= 1'b0;
            r_misroute_cnt <= '0;
        end else begin
            if (w_tx_wr) r_tx_wr_ptr <= (r_tx_wr_ptr == PtrLast) ? '0 : r_tx_wr_ptr + 1'b1;
            if (w_tx_rd) r_tx_rd_ptr <= (r_tx_rd_ptr == PtrLast) ? '0 : r_tx_rd_ptr + 1'b1;
            r_tx_cnt <= r_tx_cnt + CntW'(w_tx_wr) - CntW'(w_tx_rd);
            if (w_tx_drop) r_tx_ovf <= 1'b1;

            if (w_rx_wr) r_rx_wr_ptr <= (r_rx_wr_ptr == PtrLast) ? '0 : r_rx_wr_ptr + 1'b1;
            if (w_rx_rd) r_rx_rd_ptr <= (r_rx_rd_ptr == PtrLast) ? '0 : r_rx_rd_ptr + 1'b1;
            r_rx_cnt <= r_rx_cnt + CntW'(w_rx_wr) - CntW'(w_rx_rd);
            if (w_rx_drop) r_rx_ovf <= 1'b1;

            if (w_rx_miss && (r_misroute_cnt != 8'hFF)) r_misroute_cnt <= r_misroute_cnt + 8'd1;
        end
    end

    // Outputs depend on registers only; heads read as zero when empty.
    always_comb begin
        pndng        = (r_tx_cnt != '0);
        dev_pndng    = (r_rx_cnt != '0);
        dev_full     = w_tx_full;
        D_pop        = pndng ? r_tx_mem[r_tx_rd_ptr] : '0;
        dev_d_out    = dev_pndng ? r_rx_mem[r_rx_rd_ptr] : '0;
        tx_cnt       = r_tx_cnt;
        rx_cnt       = r_rx_cnt;
        tx_ovf       = r_tx_ovf;
        rx_ovf       = r_rx_ovf;
        misroute_cnt = r_misroute_cnt;
    end

endmodule

// File: tb/tb_bs_port_fifo.sv
// Directed bench for bs_port_fifo (id=2): TX/RX flow, overflow, filtering,
// misroute saturation and asynchronous reset.
module tb_bs_port_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        dev_push;
    logic [15:0] dev_d_in;
    logic        dev_full;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        dev_pndng;
    logic [15:0] dev_d_out;
    logic        dev_pop;
    logic [4:0]  tx_cnt;
    logic [4:0]  rx_cnt;
    logic        tx_ovf;
    logic        rx_ovf;
    logic [7:0]  misroute_cnt;

    int n_vec = 0;
    int n_err = 0;

    bs_port_fifo #(
        .pckg_sz   (16),
        .fifo_size (16),
        .id        (8'd2),
        .broadcast (8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dev_push     (dev_push),
        .dev_d_in     (dev_d_in),
        .dev_full     (dev_full),
        .pndng        (pndng),
        .D_pop        (D_pop),
        .pop          (pop),
        .push         (push),
        .D_push       (D_push),
        .dev_pndng    (dev_pndng),
        .dev_d_out    (dev_d_out),
        .dev_pop      (dev_pop),
        .tx_cnt       (tx_cnt),
        .rx_cnt       (rx_cnt),
        .tx_ovf       (tx_ovf),
        .rx_ovf       (rx_ovf),
        .misroute_cnt (misroute_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_head;
        reset    = 1'b1;
        dev_push = 1'b0;
        dev_d_in = '0;
        pop      = 1'b0;
        push     = 1'b0;
        D_push   = '0;
        dev_pop  = 1'b0;

        #45;
        check("rst_pndng", 32'(pndng), 32'h0);
        check("rst_dev_pndng", 32'(dev_pndng), 32'h0);
        check("rst_dev_full", 32'(dev_full), 32'h0);
        check("rst_D_pop", 32'(D_pop), 32'h0);
        check("rst_dev_d_out", 32'(dev_d_out), 32'h0);
        check("rst_tx_cnt", 32'(tx_cnt), 32'h0);
        check("rst_misroute", 32'(misroute_cnt), 32'h0);
        #5 reset = 1'b0;
        tick();

        // Two device writes, one-cycle show-ahead latency
        dev_push = 1'b1; dev_d_in = 16'h0101;
        tick();
        check("t1_pndng", 32'(pndng), 32'h1);
        check("t1_D_pop", 32'(D_pop), 32'h0101);
        dev_d_in = 16'h0202;
        tick();
        dev_push = 1'b0;
        check("t1_tx_cnt", 32'(tx_cnt), 32'd2);
        check("t1_head_kept", 32'(D_pop), 32'h0101);

        // Fill to 16, then overflow
        for (int i = 0; i < 14; i++) begin
            dev_push = 1'b1; dev_d_in = 16'h0300 + 16'(i);
            tick();
        end
        dev_push = 1'b0;
        check("t2_full", 32'(dev_full), 32'h1);
        check("t2_cnt16", 32'(tx_cnt), 32'd16);
        check("t2_ovf_clear", 32'(tx_ovf), 32'h0);
        dev_push = 1'b1; dev_d_in = 16'hAAAA;
        tick();
        check("t2_ovf_set", 32'(tx_ovf), 32'h1);
        check("t2_cnt_drop", 32'(tx_cnt), 32'd16);
        check("t2_head_drop", 32'(D_pop), 32'h0101);
        pop = 1'b1;
        tick();
        dev_push = 1'b0; pop = 1'b0;
        check("t2_cnt_pushpop", 32'(tx_cnt), 32'd16);
        check("t2_full_pushpop", 32'(dev_full), 32'h1);
        for (int i = 0; i < 16; i++) begin
            if (i == 0) exp_head = 16'h0202;
            else if (i < 15) exp_head = 16'h0300 + 16'(i - 1);
            else exp_head = 16'hAAAA;
            check($sformatf("t2_drain%0d", i), 32'(D_pop), 32'(exp_head));
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        check("t2_empty_cnt", 32'(tx_cnt), 32'd0);
        check("t2_empty_pndng", 32'(pndng), 32'h0);
        check("t2_empty_D_pop", 32'(D_pop), 32'h0);

        // Push and pop together on an empty FIFO; then pop when empty
        dev_push = 1'b1; dev_d_in = 16'h1234; pop = 1'b1;
        tick();
        dev_push = 1'b0;
        check("t5_cnt1", 32'(tx_cnt), 32'd1);
        check("t5_D_pop", 32'(D_pop), 32'h1234);
        tick();
        check("t5_popped", 32'(tx_cnt), 32'd0);
        tick();
        pop = 1'b0;
        check("t5_empty_pop_cnt", 32'(tx_cnt), 32'd0);
        check("t5_empty_pop_pndng", 32'(pndng), 32'h0);
        check("t5_ovf_sticky", 32'(tx_ovf), 32'h1);

        // RX filter: own ID, broadcast, foreign
        push = 1'b1; D_push = 16'h0211;
        tick();
        D_push = 16'hFF22;
        tick();
        D_push = 16'h0333;
        tick();
        push = 1'b0;
        check("t3_rx_cnt", 32'(rx_cnt), 32'd2);
        check("t3_dev_pndng", 32'(dev_pndng), 32'h1);
        check("t3_head0", 32'(dev_d_out), 32'h0211);
        check("t3_misroute", 32'(misroute_cnt), 32'd1);
        dev_pop = 1'b1;
        tick();
        check("t3_head1", 32'(dev_d_out), 32'hFF22);
        check("t3_rx_cnt1", 32'(rx_cnt), 32'd1);
        tick();
        dev_pop = 1'b0;
        check("t3_rx_empty", 32'(rx_cnt), 32'd0);
        check("t3_rx_d_zero", 32'(dev_d_out), 32'h0);

        // Misroute saturation
        push = 1'b1; D_push = 16'h0500;
        for (int i = 0; i < 253; i++) tick();
        check("t4_mis254", 32'(misroute_cnt), 32'd254);
        for (int i = 0; i < 47; i++) tick();
        push = 1'b0;
        check("t4_mis255", 32'(misroute_cnt), 32'd255);
        check("t4_rx_cnt", 32'(rx_cnt), 32'd0);

        // RX overflow
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; D_push = 16'h0200 + 16'(i);
            tick();
        end
        check("rx_ovf_clear", 32'(rx_ovf), 32'h0);
        D_push = 16'h02EE;
        tick();
        check("rx_ovf_set", 32'(rx_ovf), 32'h1);
        check("rx_cnt16", 32'(rx_cnt), 32'd16);
        D_push = 16'h02F0; dev_pop = 1'b1;
        tick();
        push = 1'b0;
        check("rx_pushpop_cnt", 32'(rx_cnt), 32'd16);
        check("rx_pushpop_head", 32'(dev_d_out), 32'h0201);
        for (int i = 0; i < 13; i++) tick();
        dev_pop = 1'b0;
        check("rx_cnt3", 32'(rx_cnt), 32'd3);
        check("rx_head_e", 32'(dev_d_out), 32'h020E);

        // Mid-stream asynchronous reset
        for (int i = 0; i < 5; i++) begin
            dev_push = 1'b1; dev_d_in = 16'h0700 + 16'(i);
            tick();
        end
        dev_push = 1'b0;
        check("t6_tx_cnt5", 32'(tx_cnt), 32'd5);
        #2 reset = 1'b1;
        #1;
        check("t6_pndng", 32'(pndng), 32'h0);
        check("t6_dev_pndng", 32'(dev_pndng), 32'h0);
        check("t6_tx_ovf", 32'(tx_ovf), 32'h0);
        check("t6_rx_ovf", 32'(rx_ovf), 32'h0);
        check("t6_misroute", 32'(misroute_cnt), 32'd0);
        check("t6_D_pop", 32'(D_pop), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        dev_push = 1'b1; dev_d_in = 16'h4444;
        tick();
        dev_push = 1'b0;
        check("t6_new_pndng", 32'(pndng), 32'h1);
        check("t6_new_D_pop", 32'(D_pop), 32'h4444);
        check("t6_new_cnt", 32'(tx_cnt), 32'd1);
        check("t6_rx_cnt", 32'(rx_cnt), 32'd0);
        check("t6_dev_d_out", 32'(dev_d_out), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
